// File: rtl/md_ctrl_pkg.sv
// Shared op codes, widths and helpers for the multiply/divide sequencer.
package md_ctrl_pkg;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned MD_DIV_STEPS = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   // Magnitude of a two's-complement value when treated as signed, raw value otherwise.
   function automatic logic [DATA_W-1:0] md_abs(input logic [DATA_W-1:0] v,
                                                input logic             is_signed);
      return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
   endfunction

endpackage

// File: rtl/md_ctrl_div_iter.sv
// One restoring radix-2 division step: shift in the next dividend bit, subtract if it fits.
module md_ctrl_div_iter
   import md_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] i_rem,
   input  logic [DATA_W-1:0] i_quo,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [DATA_W-1:0] o_rem,
   output logic [DATA_W-1:0] o_quo
);

   logic [DATA_W:0]   w_shift;
   logic [DATA_W-1:0] w_diff;

   always_comb begin
      w_shift = {i_rem, i_quo[DATA_W-1]};
      w_diff  = DATA_W'(w_shift - {1'b0, i_divisor});
      if (w_shift >= {1'b0, i_divisor}) begin
         o_rem = w_diff;
         o_quo = {i_quo[DATA_W-2:0], 1'b1};
      end else begin
         o_rem = w_shift[DATA_W-1:0];
         o_quo = {i_quo[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/md_ctrl.sv
// E-stage MULT/MULTU/DIV/DIVU sequencer driving a one-cycle HI/LO write.
// Optional: define MD_DIV_ZERO_EARLY_EN to finish divide-by-zero in one cycle.
module md_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int unsigned MULT_LAT = 2,
   parameter int unsigned CNT_W    = 6
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_E,
   input  logic [1:0]        op_E,
   input  logic [DATA_W-1:0] src_a_E,
   input  logic [DATA_W-1:0] src_b_E,
   input  logic              flush_E,
   output logic              stall_md_E,
   output logic              busy_o,
   output logic              hilo_we_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]          r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   md_op_e              r_op;
   logic [DATA_W-1:0]   r_a, r_b, r_rem, r_quo, r_hi, r_lo;

   logic                w_div_zero, w_mul_last, w_div_last, w_div_signed;
   logic [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
   logic [DATA_W-1:0]   w_divisor, w_rem_n, w_quo_n, w_rem_fix, w_quo_fix, w_lo_zero;

`ifdef MD_DIV_ZERO_EARLY_EN
   assign w_div_zero = op_E[1] & (src_b_E == '0);
`else
   assign w_div_zero = 1'b0;
`endif
   assign w_lo_zero  = (op_E == MD_DIV && src_a_E[DATA_W-1]) ? 32'h1 : 32'hFFFF_FFFF;

   assign w_mul_last = (r_cnt == CNT_W'(MULT_LAT - 1));
   assign w_div_last = (r_cnt == CNT_W'(MD_DIV_STEPS - 1));

   // Sign/zero extension to 64 bits makes one multiplier serve both signednesses.
   assign w_a_ext = r_op[0] ? {{DATA_W{1'b0}}, r_a} : {{DATA_W{r_a[DATA_W-1]}}, r_a};
   assign w_b_ext = r_op[0] ? {{DATA_W{1'b0}}, r_b} : {{DATA_W{r_b[DATA_W-1]}}, r_b};
   assign w_prod  = w_a_ext * w_b_ext;

   assign w_div_signed = (r_op == MD_DIV);
   assign w_divisor    = md_abs(r_b, w_div_signed);
   assign w_quo_fix    = (w_div_signed && (r_a[DATA_W-1] ^ r_b[DATA_W-1])) ? DATA_W'(-w_quo_n) : w_quo_n;
   assign w_rem_fix    = (w_div_signed && r_a[DATA_W-1]) ? DATA_W'(-w_rem_n) : w_rem_n;

   md_ctrl_div_iter u_div_iter (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (w_divisor),
      .o_rem     (w_rem_n),
      .o_quo     (w_quo_n)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; flush wins over everything
   always_comb begin
      w_next = r_state;
      if (flush_E) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (start_E) w_next = w_div_zero ? S_DONE : (op_E[1] ? S_DIV : S_MUL);
            S_MUL:  if (w_mul_last) w_next = S_DONE;
            S_DIV:  if (w_div_last) w_next = S_DONE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Outputs; the write is suppressed if the instruction is killed in its DONE cycle
   always_comb begin
      stall_md_E = 1'b0;
      busy_o     = 1'b0;
      hilo_we_o  = 1'b0;
      stall_md_E = start_E & ~flush_E & (r_state != S_DONE);
      busy_o     = (r_state != S_IDLE);
      hilo_we_o  = (r_state == S_DONE) & ~flush_E;
   end

   // Operand capture, step counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_op  <= MD_MULT;
         r_a   <= '0;
         r_b   <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_hi  <= '0;
         r_lo  <= '0;
      end else if (flush_E) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start_E) begin
               r_op  <= md_op_e'(op_E);
               r_a   <= src_a_E;
               r_b   <= src_b_E;
               r_cnt <= '0;
               r_rem <= '0;
               r_quo <= md_abs(src_a_E, ~op_E[0]);
               if (w_div_zero) begin
                  r_hi <= src_a_E;
                  r_lo <= w_lo_zero;
               end
            end
            S_MUL: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_mul_last) {r_hi, r_lo} <= w_prod;
            end
            S_DIV: begin
               r_cnt <= r_cnt + CNT_W'(1);
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               if (w_div_last) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign hi_o = r_hi;
   assign lo_o = r_lo;

endmodule
